// File: rtl/add_pkg.sv
// Shared configuration helpers for the add_pipe pipelined adder.
package add_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Every stage must resolve a whole, non-empty chunk.
  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result stream for add_pipe. ADD_PIPE_OVERFLOW_EN adds the ovf flag.
interface add_pipe_if
  import add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             out_valid;
  logic             out_ready;
`ifdef ADD_PIPE_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output a, b, c_in, in_valid, out_ready,
    input  in_ready, sum, c_out, out_valid
`ifdef ADD_PIPE_OVERFLOW_EN
    , input ovf
`endif
  );

  modport slave (
    input  a, b, c_in, in_valid, out_ready,
    output in_ready, sum, c_out, out_valid
`ifdef ADD_PIPE_OVERFLOW_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/add_chunk.sv
// Combinational CW-bit ripple slice; ADD_PIPE_OVERFLOW_EN exposes the carry into its MSB.
module add_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          c_in,
  output logic [CW-1:0] sum,
  output logic          c_out
`ifdef ADD_PIPE_OVERFLOW_EN
  , output logic        c_msb
`endif
);

  always_comb begin
    {c_out, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c_in};
  end

`ifdef ADD_PIPE_OVERFLOW_EN
  // The MSB sum bit is a^b^carry_in, so the carry into it can be recovered directly.
  assign c_msb = a[CW-1] ^ b[CW-1] ^ sum[CW-1];
`endif

endmodule

// File: rtl/add_pipe.sv
// Pipelined ripple-carry adder, one CW-bit chunk per stage, global-stall valid/ready flow.
// Optional macro ADD_PIPE_OVERFLOW_EN adds a registered signed-overflow output (bus.ovf).
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic       clk,
  input logic       rst,
  add_pipe_if.slave bus
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("add_pipe: WIDTH must be a multiple of STAGES, with STAGES in 1..WIDTH");
  end

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    // Operand bits from chunk s upward are still pending at this stage.
    localparam int OPW = WIDTH - s * CW;

    logic [OPW-1:0]        op_a;
    logic [OPW-1:0]        op_b;
    logic                  cy_in;
    logic                  vld_in;
    logic [CW-1:0]         ch_sum;
    logic                  ch_cy;
    logic [(s+1)*CW-1:0]   sum_next;
    logic [(s+1)*CW-1:0]   sum_d, sum_q;
    logic                  cy_d, cy_q;
    logic                  vld_d, vld_q;
`ifdef ADD_PIPE_OVERFLOW_EN
    logic                  c_msb;
`endif

    if (s == 0) begin : g_head
      assign op_a     = bus.a;
      assign op_b     = bus.b;
      assign cy_in    = bus.c_in;
      assign vld_in   = bus.in_valid;
      assign sum_next = ch_sum;
    end else begin : g_tail
      assign op_a     = g_st[s-1].g_skew.a_q;
      assign op_b     = g_st[s-1].g_skew.b_q;
      assign cy_in    = g_st[s-1].cy_q;
      assign vld_in   = g_st[s-1].vld_q;
      assign sum_next = {ch_sum, g_st[s-1].sum_q};
    end

    add_chunk #(.CW(CW)) u_chunk (
      .a     (op_a[CW-1:0]),
      .b     (op_b[CW-1:0]),
      .c_in  (cy_in),
      .sum   (ch_sum),
      .c_out (ch_cy)
`ifdef ADD_PIPE_OVERFLOW_EN
      , .c_msb (c_msb)
`endif
    );

    always_comb begin
      vld_d = vld_q;
      cy_d  = cy_q;
      sum_d = sum_q;
      if (adv) begin
        vld_d = vld_in;
        cy_d  = ch_cy;
        sum_d = sum_next;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        sum_q <= sum_d;
      end
    end

    // Upper operand chunks ride along until their carry catches up.
    if (s < STAGES - 1) begin : g_skew
      logic [OPW-CW-1:0] a_d, a_q;
      logic [OPW-CW-1:0] b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = op_a[OPW-1:CW];
          b_d = op_b[OPW-1:CW];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef ADD_PIPE_OVERFLOW_EN
    if (s == STAGES - 1) begin : g_ovf
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (adv) ovf_d = c_msb ^ ch_cy;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end
    end
`endif
  end

  assign bus.sum       = g_st[STAGES-1].sum_q;
  assign bus.c_out     = g_st[STAGES-1].cy_q;
  assign bus.out_valid = g_st[STAGES-1].vld_q;
`ifdef ADD_PIPE_OVERFLOW_EN
  assign bus.ovf       = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: reference sums from plain integer arithmetic, checked on every output transfer.
module tb_add_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_pipe_if #(.WIDTH(WIDTH)) bus_if ();

  add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             ovf;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_out   = 0;
  int               cyc     = 0;
  bit               lat_chk = 1'b0;
  logic             held_q  = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic             held_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact unsigned sum, and signed overflow as "true result out of range".
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input int c);
    exp_t   e;
    longint u;
    longint s;
    u     = longint'(a) + longint'(b) + longint'(ci);
    s     = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    e.sum = u[WIDTH-1:0];
    e.c   = u[WIDTH];
    e.ovf = (s > (2**(WIDTH-1)) - 1) || (s < -(2**(WIDTH-1)));
    e.cyc = c;
    return e;
  endfunction

  // Transfers are decided by values stable from posedge+1, so sample them at the negedge.
  always @(negedge clk) begin
    if (!rst && bus_if.in_valid && bus_if.in_ready)
      exp_q.push_back(model(bus_if.a, bus_if.b, bus_if.c_in, cyc));
  end

  always @(posedge rst) exp_q.delete();

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_q <= 1'b0;
    end else begin
      if (held_q) begin
        check("hold_valid", bus_if.out_valid, 1);
        check("hold_sum", bus_if.sum, held_sum);
        check("hold_cout", bus_if.c_out, held_c);
      end
      if (bus_if.out_valid && !bus_if.out_ready)
        check("stall_in_ready", bus_if.in_ready, 0);
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got sum 0x%0h, expected no output (t=%0t)", bus_if.sum, $time);
        end else begin
          e = exp_q.pop_front();
          check("sum", bus_if.sum, e.sum);
          check("c_out", bus_if.c_out, e.c);
`ifdef ADD_PIPE_OVERFLOW_EN
          check("ovf", bus_if.ovf, e.ovf);
`endif
          if (lat_chk) check("latency", cyc - e.cyc, STAGES);
          n_out++;
        end
      end
      held_q   <= bus_if.out_valid && !bus_if.out_ready;
      held_sum <= bus_if.sum;
      held_c   <= bus_if.c_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_if.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.c_in     = ci;
    bus_if.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        tick();
        return;
      end
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL drive_timeout: got in_ready 0 for 50 cycles, expected acceptance");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int stale;
    rst              = 1'b1;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.c_in      = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_sum", bus_if.sum, 0);
    check("rst_c_out", bus_if.c_out, 0);
    check("rst_in_ready", bus_if.in_ready, 1);
`ifdef ADD_PIPE_OVERFLOW_EN
    check("rst_ovf", bus_if.ovf, 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Single add with a cycle-by-cycle latency probe.
    lat_chk         = 1'b1;
    bus_if.a        = 16'h1234;
    bus_if.b        = 16'h0FFF;
    bus_if.c_in     = 1'b0;
    bus_if.in_valid = 1'b1;
    for (int k = 1; k <= STAGES; k++) begin
      tick();
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      check("lat_probe_valid", bus_if.out_valid, (k == STAGES));
      if (k == STAGES) begin
        check("single_sum", bus_if.sum, 16'h2233);
        check("single_cout", bus_if.c_out, 0);
      end
    end
    tick();

    // Carry ripple through every chunk, and the signed-overflow corners.
    drive(16'hFFFF, 16'h0000, 1'b1);
    drive(16'h7FFF, 16'h0001, 1'b0);
    drive(16'h8000, 16'h8000, 1'b0);
    idle(STAGES + 2);

    // Back-to-back streaming: the latency check proves there are no gaps.
    n0 = n_out;
    for (int i = 0; i < 8; i++) drive(WIDTH'(i * 16'h0101), WIDTH'(i * 16'h0101), 1'b0);
    idle(STAGES + 3);
    check("stream_count", n_out - n0, 8);
    lat_chk = 1'b0;

    // Backpressure: 6 stalled cycles, then a pop and a push in the same cycle.
    n0               = n_out;
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    idle(3);
    @(negedge clk);
    check("bp_out_valid", bus_if.out_valid, 1);
    check("bp_in_ready", bus_if.in_ready, 0);
    tick();
    bus_if.out_ready = 1'b1;
    drive(16'h4321, 16'h1111, 1'b1);
    idle(STAGES + 4);
    check("bp_count", n_out - n0, 4);

    // Randomized traffic with random bubbles and stalls.
    for (int i = 0; i < 300; i++) begin
      bus_if.a         = WIDTH'($urandom);
      bus_if.b         = WIDTH'($urandom);
      bus_if.c_in      = 1'($urandom);
      bus_if.in_valid  = ($urandom_range(0, 3) != 0);
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus_if.out_ready = 1'b1;
    idle(STAGES + 4);
    check("rand_drained", exp_q.size(), 0);

    // Async reset between edges with results in flight.
    for (int i = 1; i <= 5; i++) drive(WIDTH'(i * 16'h1111), 16'h0F0F, 1'b1);
    bus_if.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus_if.out_valid, 0);
    check("arst_sum", bus_if.sum, 0);
    check("arst_c_out", bus_if.c_out, 0);
    repeat (2) @(posedge clk);
    #2;
    rst   = 1'b0;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.out_valid) stale++;
    end
    check("no_stale_output", stale, 0);

    // Recovery after reset.
    tick();
    lat_chk = 1'b1;
    n0      = n_out;
    drive(16'hABCD, 16'h5433, 1'b0);
    idle(STAGES + 2);
    check("post_reset_count", n_out - n0, 1);
    lat_chk = 1'b0;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined ripple-carry adder. Successor to the fixed 4-bit combinational adder.
- Splits a WIDTH-bit add into STAGES chunks. Each pipeline stage resolves one chunk and registers its carry into the next stage.
- Valid/ready handshake on input and output, so it drops into streaming datapaths and can be stalled.
- Sits between operand producers (e.g. accumulators, counters) and consumers in the arithmetic library.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry into bit 0
- in_valid  in  1  a/b/c_in valid this cycle
- in_ready  out  1  adder accepts operands this cycle
- sum  out  WIDTH  registered result
- c_out  out  1  carry out of bit WIDTH-1
- out_valid  out  1  sum/c_out valid
- out_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, active-high), applied at assertion regardless of clk:
  - all stage valids, out_valid, sum, c_out and all skew/carry registers go to 0.
  - Clock runs; state changes start on the first rising edge after rst deasserts.
- Advance rule: adv = !out_valid || out_ready. Combinational; in_ready = adv.
  - All stages shift together when adv=1; all registers hold when adv=0 (global stall).
- Input transfer: in_valid && in_ready.
  - Stage-1 valid loads in_valid whenever adv=1, so bubbles propagate.
- Stage k (k=0..STAGES-1):
  - adds chunk k of a and b (bits k*CW+CW-1 : k*CW) plus the carry registered by stage k-1 (stage 0 uses c_in).
  - Produces a CW-bit partial sum and a registered carry.
- Skew/deskew:
  - Operand chunks above k are delayed k cycles so they meet their carry.
  - Completed lower sum chunks are delayed so all chunks emerge together.
- Latency: exactly STAGES cycles from input transfer to out_valid=1 with no stall. Throughput is 1 result per cycle.
- Arithmetic:
  - unsigned modulo 2^WIDTH.
  - {c_out, sum} = a + b + c_in, i.e. a WIDTH+1-bit exact result.
- Output hold: while out_valid && !out_ready, sum, c_out and out_valid stay stable and in_ready=0.
- Simultaneous output pop and input push on a full pipe: both occur in the same cycle, with no bubble.
- in_valid=0 with adv=1: a bubble enters. Data registers may take any value, but valid=0.
- STAGES=1 degenerates to a registered adder with latency 1.
- Reset mid-operation: all in-flight results are discarded (no out_valid after release until new input plus STAGES cycles).

Optional Feature:
- Macro: ADD_PIPE_OVERFLOW_EN.
- Defined: extra output port ovf (1 bit), aligned with sum and valid under out_valid.
  - ovf = two's-complement signed overflow = carry into MSB XOR carry out of MSB.
  - Reset value 0.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package add_pkg:
  - localparam helpers for CW;
  - width-check constant (WIDTH % STAGES == 0);
  - elaboration error on violation.
- Sub-module add_chunk:
  - combinational CW-bit slice (a, b, c_in -> sum, c_out).
  - Instantiated STAGES times via generate.
  - Also exposes carry-into-MSB for the overflow option.
- Top holds all registers, skew/deskew arrays and handshake.

Test Plan:
- Reset then single add, WIDTH=16, STAGES=4: a=0x1234, b=0x0FFF, c_in=0 -> after exactly 4 cycles out_valid=1, sum=0x2233, c_out=0.
- Full carry ripple across all chunks: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1.
- Back-to-back streaming:
  - stimulus: 8 consecutive inputs {a,b}=i*0x0101, i=0..7, with out_ready=1.
  - required: 8 consecutive out_valid cycles starting at cycle 4, each sum = 2*i*0x0101, no gaps.
- Backpressure:
  - stimulus: out_ready=0 for 6 cycles while feeding 3 inputs.
  - required: pipe fills, in_ready drops, the held output is stable. On release the results drain in order, none lost or duplicated.
- Async reset mid-stream: assert rst between clock edges with 3 results in flight -> out_valid=0, sum=0, c_out=0 immediately; no stale output after deassertion.
- With ADD_PIPE_OVERFLOW_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
